map_probe_arbiter: RTL and testbench

Shares one registered Map wall-lookup port between two characters (Fireboy = requester 0, Watergirl = requester 1). Today each character instantiates four combinational Map copies for its up, down, left and right probes. This block replaces them with one time-multiplexed lookup. For each granted request it issues the four probe coordinates back-to-back, collects the wall results, and returns a 4-bit wall vector with a done pulse. It sits between the character movement modules and the single Map instance at top level.

---
 rtl/map_probe_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_map_probe_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_probe_arbiter.sv
// rtl/map_probe_arbiter.sv - one shared Map wall-lookup port time-multiplexed between two characters
//
// Each granted request issues its four probes (up, down, left, right) on the
// shared Map port on consecutive cycles, ORs in an off-screen check per probe,
// and returns a 4-bit wall vector {right,left,down,up} with a one-cycle done.
//
// Ports:
//   Clk, Reset                       clock, synchronous active-low reset
//   req[1:0]                         level requests, bit0 Fireboy, bit1 Watergirl
//   probe_x0/y0, probe_x1/y1 [39:0]  per-requester probe coordinates, 10 bits each
//   map_x, map_y, map_rd             shared lookup address and strobe (registered)
//   map_is_wall                      lookup result, valid MAP_LAT cycles after map_rd
//   grant[1:0], busy                 requester being served, FSM not idle
//   done[1:0]                        result-ready pulse per requester
//   wall_flags0/1 [3:0]              last result per requester, held between updates

module map_probe_arbiter #(
    parameter int MAP_LAT = 1,
    parameter int X_MAX   = 639,
    parameter int Y_MAX   = 479
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  req,
    input  logic [39:0] probe_x0,
    input  logic [39:0] probe_y0,
    input  logic [39:0] probe_x1,
    input  logic [39:0] probe_y1,
    output logic [9:0]  map_x,
    output logic [9:0]  map_y,
    output logic        map_rd,
    input  logic        map_is_wall,
    output logic [1:0]  grant,
    output logic        busy,
    output logic [1:0]  done,
    output logic [3:0]  wall_flags0,
    output logic [3:0]  wall_flags1
);

    localparam logic [9:0] X_LIM = 10'(X_MAX);
    localparam logic [9:0] Y_LIM = 10'(Y_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                    state_q, state_d;
    logic [1:0]                cnt_q, cnt_d;
    logic                      last_q, last_d;
    logic [1:0]                mask_q, mask_d;
    logic [39:0]               shx_q, shx_d;
    logic [39:0]               shy_q, shy_d;
    logic [3:0]                acc_q, acc_d;
    logic [1:0]                grant_q, grant_d;
    logic                      busy_q, busy_d;
    logic [1:0]                done_q, done_d;
    logic                      rd_q, rd_d;
    logic [9:0]                mx_q, mx_d;
    logic [9:0]                my_q, my_d;
    logic [3:0]                wf0_q, wf0_d;
    logic [3:0]                wf1_q, wf1_d;
    // Lookup pipeline: valid bit and probe index travel alongside the Map latency.
    logic [MAP_LAT-1:0]        pv_q, pv_d;
    logic [MAP_LAT-1:0][1:0]   pidx_q, pidx_d;

    logic        cap_v;
    logic [1:0]  cap_k;
    logic [1:0]  req_m;
    logic        win;
    logic [39:0] win_x;
    logic [39:0] win_y;
    logic [1:0]  nxt_k;

    function automatic logic [9:0] pick(input logic [39:0] v, input logic [1:0] k);
        case (k)
            2'd0:    pick = v[9:0];
            2'd1:    pick = v[19:10];
            2'd2:    pick = v[29:20];
            default: pick = v[39:30];
        endcase
    endfunction

    // Unsigned compare: a coordinate that wrapped below zero is treated as a wall.
    function automatic logic off_screen(input logic [9:0] x, input logic [9:0] y);
        off_screen = (x > X_LIM) || (y > Y_LIM);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        mask_d  = mask_q;
        shx_d   = shx_q;
        shy_d   = shy_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        done_d  = 2'b00;
        rd_d    = 1'b0;
        mx_d    = mx_q;
        my_d    = my_q;
        wf0_d   = wf0_q;
        wf1_d   = wf1_q;

        pv_d      = pv_q;
        pidx_d    = pidx_q;
        pv_d[0]   = rd_q;
        pidx_d[0] = cnt_q;
        for (int i = 1; i < MAP_LAT; i++) begin
            pv_d[i]   = pv_q[i-1];
            pidx_d[i] = pidx_q[i-1];
        end

        cap_v = pv_q[MAP_LAT-1];
        cap_k = pidx_q[MAP_LAT-1];
        acc_d = acc_q;
        if (cap_v) begin
            acc_d[cap_k] = map_is_wall | off_screen(pick(shx_q, cap_k), pick(shy_q, cap_k));
        end

        // The requester just served is ignored for one IDLE cycle so a late
        // req drop cannot win it a second turn.
        req_m = req & ~mask_q;
        win   = (req_m == 2'b11) ? ~last_q : req_m[1];
        win_x = win ? probe_x1 : probe_x0;
        win_y = win ? probe_y1 : probe_y0;
        nxt_k = cnt_q + 2'd1;

        case (state_q)
            IDLE: begin
                mask_d = 2'b00;
                if (|req_m) begin
                    state_d = ISSUE;
                    shx_d   = win_x;
                    shy_d   = win_y;
                    grant_d = win ? 2'b10 : 2'b01;
                    last_d  = win;
                    busy_d  = 1'b1;
                    cnt_d   = 2'd0;
                    acc_d   = 4'b0000;
                    rd_d    = 1'b1;
                    mx_d    = win_x[9:0];
                    my_d    = win_y[9:0];
                end
            end
            ISSUE: begin
                cnt_d = nxt_k;
                // Counter wraps to 0 on the last probe; no strobe goes with the wrap.
                if (cnt_q == 2'd3) begin
                    state_d = DRAIN;
                end else begin
                    rd_d = 1'b1;
                    mx_d = pick(shx_q, nxt_k);
                    my_d = pick(shy_q, nxt_k);
                end
            end
            DRAIN: begin
                if (cap_v && cap_k == 2'd3) begin
                    state_d = DONE;
                    done_d  = grant_q;
                    if (grant_q[1]) begin
                        wf1_d = acc_d;
                    end else begin
                        wf0_d = acc_d;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = 2'b00;
                busy_d  = 1'b0;
                mask_d  = grant_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            last_q  <= 1'b1;
            mask_q  <= 2'b00;
            shx_q   <= '0;
            shy_q   <= '0;
            acc_q   <= 4'b0000;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 2'b00;
            rd_q    <= 1'b0;
            mx_q    <= '0;
            my_q    <= '0;
            wf0_q   <= 4'b0000;
            wf1_q   <= 4'b0000;
            pv_q    <= '0;
            pidx_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            mask_q  <= mask_d;
            shx_q   <= shx_d;
            shy_q   <= shy_d;
            acc_q   <= acc_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            wf0_q   <= wf0_d;
            wf1_q   <= wf1_d;
            pv_q    <= pv_d;
            pidx_q  <= pidx_d;
        end
    end

    assign map_x       = mx_q;
    assign map_y       = my_q;
    assign map_rd      = rd_q;
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign wall_flags0 = wf0_q;
    assign wall_flags1 = wf1_q;

endmodule

// File: tb/tb_map_probe_arbiter.sv
// tb/tb_map_probe_arbiter.sv - self-checking bench for map_probe_arbiter

module tb_map_probe_arbiter;

    localparam int LAT = 1;
    localparam logic [39:0] PX_A = {10'd101, 10'd96, 10'd100, 10'd100};
    localparam logic [39:0] PY_A = {10'd100, 10'd100, 10'd103, 10'd100};
    localparam logic [39:0] PX_B = {10'd6, 10'd20, 10'd21, 10'd22};
    localparam logic [39:0] PY_B = {10'd8, 10'd8, 10'd7, 10'd8};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst3_n;
    logic [1:0]  req, req3;
    logic [39:0] px0, py0, px1, py1;
    logic [39:0] px3_0, py3_0, px3_1, py3_1;
    logic        wall_en;

    logic [9:0]  mx, my, mx3, my3;
    logic        rd, rd3, busy, busy3;
    logic [1:0]  grant, grant3, done, done3;
    logic [3:0]  wf0, wf1, wf0_3, wf1_3;
    logic        wall1 = 1'b0;
    logic [2:0]  w3 = 3'b000;
    logic        wall3;

    map_probe_arbiter #(.MAP_LAT(1)) dut (
        .Clk(clk), .Reset(rst_n), .req(req),
        .probe_x0(px0), .probe_y0(py0), .probe_x1(px1), .probe_y1(py1),
        .map_x(mx), .map_y(my), .map_rd(rd), .map_is_wall(wall1),
        .grant(grant), .busy(busy), .done(done),
        .wall_flags0(wf0), .wall_flags1(wf1)
    );

    map_probe_arbiter #(.MAP_LAT(3)) dut3 (
        .Clk(clk), .Reset(rst3_n), .req(req3),
        .probe_x0(px3_0), .probe_y0(py3_0), .probe_x1(px3_1), .probe_y1(py3_1),
        .map_x(mx3), .map_y(my3), .map_rd(rd3), .map_is_wall(wall3),
        .grant(grant3), .busy(busy3), .done(done3),
        .wall_flags0(wf0_3), .wall_flags1(wf1_3)
    );

    function automatic logic wall_at(input logic [9:0] x, input logic [9:0] y);
        return (x[3:0] == 4'd5) || (y[3:0] == 4'd7);
    endfunction

    function automatic logic [3:0] exp_flags(input logic en, input logic [39:0] px, input logic [39:0] py);
        logic [39:0] tx, ty;
        logic [3:0]  r;
        for (int k = 0; k < 4; k++) begin
            tx = px >> (10 * k);
            ty = py >> (10 * k);
            r[k] = (en && wall_at(tx[9:0], ty[9:0])) || (tx[9:0] > 10'd639) || (ty[9:0] > 10'd479);
        end
        return r;
    endfunction

    // Map models: walls per wall_at, delivered 1 and 3 cycles after the strobe.
    always @(posedge clk) wall1 <= rd && wall_en && wall_at(mx, my);
    always @(posedge clk) w3 <= {w3[1:0], rd3 && wall_en && wall_at(mx3, my3)};
    assign wall3 = w3[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, want);
        end
    endtask

    // Transaction-level model of the LAT=1 instance.
    bit          mv = 1'b0;
    bit          m_act = 1'b0;
    int          m_T = 0;
    logic        m_who, m_last;
    logic [9:0]  m_x [4];
    logic [9:0]  m_y [4];
    logic [3:0]  m_res;
    logic [3:0]  m_flags [2];
    logic [1:0]  m_mask;
    logic [9:0]  m_lx, m_ly;
    logic [1:0]  e_grant, e_done, rm;
    logic        e_busy, e_rd;
    logic [39:0] sx, sy, tx, ty;

    initial begin
        forever begin
            @(negedge clk);
            if (mv) begin
                e_grant = 2'b00; e_busy = 1'b0; e_rd = 1'b0; e_done = 2'b00;
                if (m_act && cyc > m_T && cyc <= m_T + 5 + LAT) begin
                    e_grant = m_who ? 2'b10 : 2'b01;
                    e_busy  = 1'b1;
                    if (cyc <= m_T + 4) begin
                        e_rd = 1'b1;
                        m_lx = m_x[cyc - m_T - 1];
                        m_ly = m_y[cyc - m_T - 1];
                    end
                    if (cyc == m_T + 5 + LAT) begin
                        e_done = e_grant;
                        m_flags[m_who] = m_res;
                    end
                end
                chk("m_grant", 32'(grant), 32'(e_grant));
                chk("m_busy",  32'(busy),  32'(e_busy));
                chk("m_rd",    32'(rd),    32'(e_rd));
                chk("m_done",  32'(done),  32'(e_done));
                chk("m_map_x", 32'(mx),    32'(m_lx));
                chk("m_map_y", 32'(my),    32'(m_ly));
                chk("m_wf0",   32'(wf0),   32'(m_flags[0]));
                chk("m_wf1",   32'(wf1),   32'(m_flags[1]));
            end
            if (!rst_n) begin
                mv = 1'b1; m_act = 1'b0; m_last = 1'b1; m_mask = 2'b00;
                m_flags[0] = 4'b0000; m_flags[1] = 4'b0000; m_lx = '0; m_ly = '0;
            end else if (mv) begin
                if (m_act) begin
                    if (cyc == m_T + 5 + LAT) begin
                        m_act  = 1'b0;
                        m_mask = m_who ? 2'b10 : 2'b01;
                    end
                end else begin
                    rm = req & ~m_mask;
                    m_mask = 2'b00;
                    if (rm != 2'b00) begin
                        m_who  = (rm == 2'b11) ? ~m_last : rm[1];
                        m_last = m_who;
                        m_act  = 1'b1;
                        m_T    = cyc;
                        sx = m_who ? px1 : px0;
                        sy = m_who ? py1 : py0;
                        for (int k = 0; k < 4; k++) begin
                            tx = sx >> (10 * k);
                            ty = sy >> (10 * k);
                            m_x[k] = tx[9:0];
                            m_y[k] = ty[9:0];
                        end
                        m_res = exp_flags(wall_en, sx, sy);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_cyc(input int n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
    endtask

    int t, prev, n;

    initial begin
        rst_n = 1'b0; rst3_n = 1'b0; req = 2'b00; req3 = 2'b00; wall_en = 1'b1;
        px0 = '0; py0 = '0; px1 = '0; py1 = '0;
        px3_0 = '0; py3_0 = '0; px3_1 = '0; py3_1 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; rst3_n = 1'b1;
        at_cyc(cyc);
        chk("rst_grant", 32'(grant), 32'(2'b00));
        chk("rst_busy",  32'(busy),  32'(1'b0));
        chk("rst_rd",    32'(rd),    32'(1'b0));
        chk("rst_map_x", 32'(mx),    32'(10'd0));
        chk("rst_wf0",   32'(wf0),   32'(4'b0000));
        chk("rst_busy3", 32'(busy3), 32'(1'b0));

        // Single request: walls on down and right probes.
        tick(); px0 = PX_A; py0 = PY_A; req = 2'b01; t = cyc;
        at_cyc(t + 1);
        chk("t1_rd_first", 32'(rd), 32'(1'b1));
        chk("t1_up_x", 32'(mx), 32'(10'd100));
        chk("t1_up_y", 32'(my), 32'(10'd100));
        at_cyc(t + 2);
        chk("t1_down_y", 32'(my), 32'(10'd103));
        at_cyc(t + 4);
        chk("t1_right_x", 32'(mx), 32'(10'd101));
        at_cyc(t + 5);
        chk("t1_rd_off", 32'(rd), 32'(1'b0));
        chk("t1_no_early_done", 32'(done), 32'(2'b00));
        at_cyc(t + 6);
        chk("t1_done", 32'(done), 32'(2'b01));
        chk("t1_wf0", 32'(wf0), 32'(4'b1010));
        chk("t1_wf1", 32'(wf1), 32'(4'b0000));
        tick(); req = 2'b00;
        repeat (2) tick();

        // Coordinates latched at grant; req dropped mid-operation.
        px0 = PX_A; py0 = PY_A; req = 2'b01; t = cyc;
        tick(); px0 = {4{10'd7}}; req = 2'b00;
        at_cyc(t + 2);
        chk("t5_down_x", 32'(mx), 32'(10'd100));
        at_cyc(t + 3);
        chk("t5_left_x", 32'(mx), 32'(10'd96));
        at_cyc(t + 4);
        chk("t5_right_x", 32'(mx), 32'(10'd101));
        at_cyc(t + 6);
        chk("t5_done", 32'(done), 32'(2'b01));
        chk("t5_wf0", 32'(wf0), 32'(4'b1010));
        repeat (3) tick();

        // Off-screen probes with an empty map.
        wall_en = 1'b0;
        repeat (2) tick();
        px0 = {4{10'd50}}; py0 = {10'd60, 10'd60, 10'd60, 10'h3FF}; req = 2'b01; t = cyc;
        at_cyc(t + 6);
        chk("t4_done0", 32'(done), 32'(2'b01));
        chk("t4_wf0", 32'(wf0), 32'(4'b0001));
        tick(); req = 2'b00;
        tick();
        px1 = {10'd639, 10'd640, 10'd10, 10'd10}; py1 = {10'd0, 10'd0, 10'd480, 10'd479};
        req = 2'b10; t = cyc;
        at_cyc(t + 6);
        chk("t4_done1", 32'(done), 32'(2'b10));
        chk("t4_wf1", 32'(wf1), 32'(4'b0110));
        chk("t4_wf0_kept", 32'(wf0), 32'(4'b0001));
        tick(); req = 2'b00;
        wall_en = 1'b1;
        repeat (2) tick();

        // Simultaneous requests right after reset.
        rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        at_cyc(cyc);
        chk("t2_rst_wf0", 32'(wf0), 32'(4'b0000));
        chk("t2_rst_wf1", 32'(wf1), 32'(4'b0000));
        tick();
        px0 = PX_A; py0 = PY_A; px1 = PX_B; py1 = PY_B; req = 2'b11; t = cyc;
        at_cyc(t + 6);
        chk("t2_done0", 32'(done), 32'(2'b01));
        tick(); req = 2'b10;
        at_cyc(t + 13);
        chk("t2_done1", 32'(done), 32'(2'b10));
        chk("t2_wf1", 32'(wf1), 32'(4'b0010));
        chk("t2_wf0", 32'(wf0), 32'(4'b1010));
        tick(); req = 2'b00;
        repeat (2) tick();

        // Continuous contention: strict alternation every 7 cycles.
        req = 2'b11;
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            n = 0;
            @(negedge clk);
            while (done == 2'b00 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) begin
                chk("t3_timeout", 32'(done), 32'(2'b11));
            end else begin
                chk("t3_who", 32'(done), (i % 2 == 0) ? 32'd1 : 32'd2);
                if (i > 0) chk("t3_period", 32'(cyc - prev), 32'd7);
                prev = cyc;
            end
        end
        tick(); req = 2'b00;
        repeat (3) tick();

        // MAP_LAT=3: reset during DRAIN, then a normal request.
        px3_0 = PX_A; py3_0 = PY_A; req3 = 2'b01; t = cyc;
        at_cyc(t + 5);
        chk("t6_drain_busy", 32'(busy3), 32'(1'b1));
        chk("t6_drain_rd", 32'(rd3), 32'(1'b0));
        tick(); rst3_n = 1'b0; req3 = 2'b00;
        tick(); rst3_n = 1'b1;
        at_cyc(t + 7);
        chk("t6_busy", 32'(busy3), 32'(1'b0));
        chk("t6_grant", 32'(grant3), 32'(2'b00));
        chk("t6_wf0", 32'(wf0_3), 32'(4'b0000));
        for (int j = 0; j <= 5; j++) begin
            at_cyc(t + 7 + j);
            chk("t6_no_done", 32'(done3), 32'(2'b00));
        end
        tick();
        px3_1 = PX_A; py3_1 = PY_A; req3 = 2'b10; t = cyc;
        at_cyc(t + 1);
        chk("t6_rd", 32'(rd3), 32'(1'b1));
        chk("t6_up_x", 32'(mx3), 32'(10'd100));
        at_cyc(t + 7);
        chk("t6_done_early", 32'(done3), 32'(2'b00));
        at_cyc(t + 8);
        chk("t6_done", 32'(done3), 32'(2'b10));
        chk("t6_wf1", 32'(wf1_3), 32'(4'b1010));
        chk("t6_wf0_kept", 32'(wf0_3), 32'(4'b0000));
        tick(); req3 = 2'b00;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

endmodule
